// File: rtl/msg_tx_sequencer.sv
// msg_tx_sequencer
//   Streams one NUL-terminated message out of a string ROM into a byte-wide
//   transmitter (e.g. UART TX) over a valid/ready handshake. The ROM holds
//   2**SEL_W messages, each in a fixed MSG_STRIDE-byte slot at sel*MSG_STRIDE.
//   A message ends at the first 0x00 byte or at the end of its slot.
//
//   Optional feature macro: MSG_AUTOREPEAT_EN
//     defined   -> after completion with i_repeat=1, wait GAP_CYCLES idle cycles
//                  and replay the same message.
//     undefined -> completion always returns to idle; i_repeat is unused.
//
// Ports
//   i_clock, i_reset_n   clock (posedge) and asynchronous active-low reset
//   i_start, i_msg_sel   start request (idle only) and message index
//   i_abort              drop the current message, back to idle next cycle
//   i_repeat             auto-repeat enable (MSG_AUTOREPEAT_EN only)
//   o_rom_addr           ROM read address (synchronous ROM, 1-cycle latency)
//   i_rom_data           ROM read data
//   o_tx_valid/o_tx_data/i_tx_ready   byte handshake towards the transmitter
//   o_busy               high whenever not idle
//   o_done               one-cycle pulse on normal completion
//   o_count              bytes accepted in the current/last message
module msg_tx_sequencer #(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned MSG_STRIDE = 16,
  parameter int unsigned GAP_CYCLES = 1000
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [SEL_W-1:0]  i_msg_sel,
  input  logic              i_abort,
  input  logic              i_repeat,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [7:0]        i_rom_data,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [7:0]        o_count
);

  // One extra bit so the offset can reach MSG_STRIDE itself (slot exhausted).
  localparam int unsigned OffW = $clog2(MSG_STRIDE) + 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAddr = 3'd1;
  localparam logic [2:0] StData = 3'd2;
  localparam logic [2:0] StSend = 3'd3;
  localparam logic [2:0] StDone = 3'd4;
`ifdef MSG_AUTOREPEAT_EN
  localparam logic [2:0] StGap  = 3'd5;
  localparam int unsigned GapW  = $clog2(GAP_CYCLES + 1);
`endif

  logic [2:0]        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [OffW-1:0]   offset_q, offset_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        count_q, count_d;
`ifdef MSG_AUTOREPEAT_EN
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = i_repeat ^ (GAP_CYCLES == 0);
`endif

  logic [ADDR_W-1:0] base_addr;
  logic [OffW-1:0]   offset_inc;

  function automatic logic [ADDR_W-1:0] slot_base(input logic [SEL_W-1:0] sel);
    return ADDR_W'(sel) * ADDR_W'(MSG_STRIDE);
  endfunction

  assign base_addr  = slot_base(sel_q);
  assign offset_inc = offset_q + OffW'(1);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    offset_d   = offset_q;
    rom_addr_d = rom_addr_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    count_d    = count_q;
`ifdef MSG_AUTOREPEAT_EN
    gap_cnt_d  = gap_cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (i_start) begin
          sel_d      = i_msg_sel;
          offset_d   = '0;
          count_d    = '0;
          rom_addr_d = slot_base(i_msg_sel);
          state_d    = StAddr;
        end
      end
      StAddr: state_d = StData;
      StData: begin
        if (i_rom_data == 8'h00) begin
          state_d = StDone;
        end else begin
          tx_data_d  = i_rom_data;
          tx_valid_d = 1'b1;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (i_tx_ready) begin
          tx_valid_d = 1'b0;
          count_d    = count_q + 8'd1;
          offset_d   = offset_inc;
          if (offset_inc == OffW'(MSG_STRIDE)) begin
            state_d = StDone;
          end else begin
            rom_addr_d = base_addr + ADDR_W'(offset_inc);
            state_d    = StAddr;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
`ifdef MSG_AUTOREPEAT_EN
        if (i_repeat) begin
          state_d   = StGap;
          gap_cnt_d = '0;
        end
`endif
      end
`ifdef MSG_AUTOREPEAT_EN
      StGap: begin
        if (!i_repeat) begin
          state_d = StIdle;
        end else if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
          offset_d   = '0;
          count_d    = '0;
          rom_addr_d = base_addr;
          state_d    = StAddr;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Abort wins over everything except a coincident accept, whose count stays.
    if (i_abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      offset_q   <= '0;
      rom_addr_q <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      count_q    <= '0;
`ifdef MSG_AUTOREPEAT_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      offset_q   <= offset_d;
      rom_addr_q <= rom_addr_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      count_q    <= count_d;
`ifdef MSG_AUTOREPEAT_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  assign o_rom_addr = rom_addr_q;
  assign o_tx_valid = tx_valid_q;
  assign o_tx_data  = tx_data_q;
  assign o_count    = count_q;
  assign o_busy     = (state_q != StIdle);
  assign o_done     = (state_q == StDone);

endmodule

// File: tb/tb_msg_tx_sequencer.sv
// Self-checking bench for msg_tx_sequencer: directed scenarios plus randomized
// messages and ready patterns, checked against a slot/NUL model of the ROM.
module tb_msg_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [1:0] i_msg_sel = '0;
  logic       i_abort = 1'b0;
  logic       i_repeat = 1'b0;
  logic [6:0] o_rom_addr;
  logic [7:0] i_rom_data;
  logic       o_tx_valid;
  logic [7:0] o_tx_data;
  logic       i_tx_ready = 1'b1;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_count;

  always #5 clk = ~clk;

  msg_tx_sequencer #(
    .ADDR_W    (7),
    .SEL_W     (2),
    .MSG_STRIDE(16),
    .GAP_CYCLES(10)
  ) u_dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_start   (i_start),
    .i_msg_sel (i_msg_sel),
    .i_abort   (i_abort),
    .i_repeat  (i_repeat),
    .o_rom_addr(o_rom_addr),
    .i_rom_data(i_rom_data),
    .o_tx_valid(o_tx_valid),
    .o_tx_data (o_tx_data),
    .i_tx_ready(i_tx_ready),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_count   (o_count)
  );

  // Synchronous ROM model, one-cycle read latency.
  logic [7:0] rom [128];
  always @(posedge clk) i_rom_data <= rom[o_rom_addr];

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the message is the slot contents up to the first NUL or slot end.
  logic [7:0] exp_q[$];
  function automatic void build_exp(input int sel);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (rom[sel * 16 + i] == 8'h00) break;
      exp_q.push_back(rom[sel * 16 + i]);
    end
  endfunction

  // Monitor: collects accepted bytes, done pulses, stalls and address range.
  logic [7:0] got_q[$];
  int         done_cnt = 0;
  int         stall_cnt = 0;
  int         max_addr = 0;
  int         cur_sel = 0;
  logic [7:0] stall_byte = '0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", o_tx_valid, 1);
        check("hold_data", o_tx_data, prev_data);
      end
      if (o_tx_valid && i_tx_ready) got_q.push_back(o_tx_data);
      if (o_tx_valid && !i_tx_ready) begin
        stall_cnt++;
        stall_byte = o_tx_data;
      end
      if (o_done) done_cnt++;
      if (o_busy) begin
        check("addr_in_slot", o_rom_addr / 16, cur_sel);
        if (int'(o_rom_addr) > max_addr) max_addr = o_rom_addr;
      end
      prev_stall = o_tx_valid && !i_tx_ready && !i_abort;
      prev_data  = o_tx_data;
    end
  end

  // Ready driver: 0 = always ready, 1 = random, 2 = stall 5 cycles on the 3rd byte.
  int ready_mode = 0;
  int stall_left = 0;
  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      1: i_tx_ready = 1'($urandom_range(0, 1));
      2: begin
        if (o_tx_valid && got_q.size() == 2 && stall_left > 0) begin
          i_tx_ready = 1'b0;
          stall_left--;
        end else begin
          i_tx_ready = 1'b1;
        end
      end
      default: i_tx_ready = 1'b1;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && o_busy; i++) step();
    check(tag, o_busy, 0);
  endtask

  // Starts message sel, checks the start latency and the full transfer.
  task automatic run_msg(input int sel, input int mode, input string tag);
    build_exp(sel);
    ready_mode = mode;
    cur_sel    = sel;
    got_q.delete();
    done_cnt  = 0;
    stall_cnt = 0;
    max_addr  = 0;
    i_start   = 1'b1;
    i_msg_sel = 2'(sel);
    step();
    i_start   = 1'b0;
    i_msg_sel = 2'($urandom_range(0, 3));
    check({tag, "_addr0"}, o_rom_addr, sel * 16);
    check({tag, "_busy"}, o_busy, 1);
    step();
    check({tag, "_lat_n2"}, o_tx_valid, 0);
    step();
    check({tag, "_lat_valid"}, o_tx_valid, exp_q.size() != 0);
    check({tag, "_lat_done"}, o_done, exp_q.size() == 0);
    wait_idle({tag, "_timeout"});
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_count"}, o_count, exp_q.size());
    check({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_byte"}, got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    string hello;
    hello = "Hello world";
    for (int i = 0; i < 128; i++) rom[i] = 8'h00;
    for (int i = 0; i < hello.len(); i++) rom[i] = hello[i];
    for (int i = 0; i < 16; i++) rom[32 + i] = 8'(8'hA0 + i);
    rom[16] = 8'h00;
    for (int i = 1; i < 16; i++) rom[16 + i] = 8'h55;

    // Reset values.
    #12;
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_tx_valid, 0);
    check("rst_done", o_done, 0);
    check("rst_count", o_count, 0);
    check("rst_addr", o_rom_addr, 0);
    check("rst_data", o_tx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Hello world, ready always high.
    run_msg(0, 0, "hello");

    // Transmitter stalls for 5 cycles on the third byte.
    stall_left = 5;
    run_msg(0, 2, "stall");
    check("stall_cycles", stall_cnt, 5);
    check("stall_byte", stall_byte, 8'h6C);

    // Empty message.
    run_msg(1, 0, "empty");

    // Full slot without NUL.
    run_msg(2, 0, "full");
    check("full_max_addr", max_addr, 47);

    // Abort after the 4th accept with a coincident start.
    build_exp(0);
    ready_mode = 0;
    cur_sel    = 0;
    got_q.delete();
    done_cnt  = 0;
    i_start   = 1'b1;
    i_msg_sel = 2'd0;
    step();
    i_start = 1'b0;
    for (int i = 0; i < 100 && got_q.size() < 4; i++) @(negedge clk);
    check("abort_reach4", got_q.size(), 4);
    step();
    i_abort = 1'b1;
    i_start = 1'b1;
    step();
    i_abort = 1'b0;
    i_start = 1'b0;
    check("abort_idle", o_busy, 0);
    check("abort_valid", o_tx_valid, 0);
    check("abort_count", o_count, 4);
    repeat (4) step();
    check("abort_start_ignored", o_busy, 0);
    check("abort_no_done", done_cnt, 0);

    // Async reset in the middle of a message.
    cur_sel = 2;
    i_start = 1'b1;
    i_msg_sel = 2'd2;
    step();
    i_start = 1'b0;
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", o_busy, 0);
    check("arst_valid", o_tx_valid, 0);
    check("arst_count", o_count, 0);
    check("arst_addr", o_rom_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Random slot-3 contents, random selection and random ready.
    for (int it = 0; it < 12; it++) begin
      int nul_pos;
      nul_pos = $urandom_range(0, 22);
      for (int i = 0; i < 16; i++) begin
        rom[48 + i] = (i == nul_pos) ? 8'h00 : 8'($urandom_range(1, 255));
      end
      run_msg((it % 2 == 0) ? 3 : int'($urandom_range(0, 3)), 1, "rand");
    end

`ifdef MSG_AUTOREPEAT_EN
    // Auto-repeat: 10 busy gap cycles between the done pulse and the next ADDR.
    begin
      int k;
      ready_mode = 0;
      cur_sel    = 0;
      i_repeat   = 1'b1;
      i_start    = 1'b1;
      i_msg_sel  = 2'd0;
      step();
      i_start = 1'b0;
      for (int i = 0; i < 200 && !o_done; i++) step();
      check("rep_done_seen", o_done, 1);
      k = 0;
      for (int i = 0; i < 100 && !o_tx_valid; i++) begin
        step();
        k++;
      end
      // done -> 10 gap cycles -> ADDR -> DATA -> valid
      check("rep_gap_len", k, 13);
      check("rep_count_restart", o_count, 0);
      i_repeat = 1'b0;
      i_abort  = 1'b1;
      step();
      i_abort = 1'b0;
      check("rep_abort_idle", o_busy, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
